// File: rtl/carrier_pkg.sv
// Shared types and constants for the carrier waveform sequencer.
package carrier_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int ROM_DEPTH = 32;
    localparam int ACC_W_DEF = 16;
    localparam int ADDR_W_DEF = $clog2(ROM_DEPTH);

    // One ROM address step per clk at the default widths.
    localparam logic [ACC_W_DEF-1:0] DEFAULT_TUNING = 16'h0800;

endpackage

// File: rtl/carrier_phase_acc.sv
// Phase accumulator: ACC_W register with clear, enable and increment input.
// wrap_next is the carry of the pending add, so the FSM can act on a wrap
// at the same edge that performs it; wrap_n_q is the registered (active-low)
// record that the last update carried.
module carrier_phase_acc
    import carrier_pkg::*;
#(
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clr,
    input  logic [ACC_W-1:0]  inc,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap_next,
    output logic              wrap_n_q
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             wrap_n_d;
    logic [ACC_W:0]   sum;

    assign sum       = {1'b0, acc_q} + {1'b0, inc};
    assign wrap_next = sum[ACC_W];
    assign addr      = acc_q[ACC_W-1 -: ADDR_W];

    // Next accumulator value; clear wins over enable.
    always_comb begin
        acc_d    = acc_q;
        wrap_n_d = 1'b1;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d    = sum[ACC_W-1:0];
            wrap_n_d = ~sum[ACC_W];
        end
    end

    // Accumulator and wrap flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q    <= '0;
            wrap_n_q <= 1'b1;
        end else begin
            acc_q    <= acc_d;
            wrap_n_q <= wrap_n_d;
        end
    end

endmodule

// File: rtl/carrier_sequencer.sv
// Carrier ROM/DA sequencer: programmable-rate address generation with
// period-boundary configuration updates, burst or continuous output.
//
// state  | meaning
// IDLE   | DA blanked, address held at 0, config applied directly
// RUN    | accumulator stepping, DA unblanked, sync on each wrap
// FINISH | one-cycle run end: blank, clear, done pulse
module carrier_sequencer
    import carrier_pkg::*;
#(
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_tuning,
    input  logic [1:0]        cfg_wave,
    input  logic [CNT_W-1:0]  cfg_cycles,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        wave_sel,
    output logic              clk_DA,
    output logic              blank_DA_n,
    output logic              sync_DA_n,
    output logic              busy,
    output logic              done
);

    localparam logic [ACC_W-1:0] RESET_TUNING = ACC_W'(1) << (ACC_W - ADDR_W);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] tuning_q, tuning_d, sh_tuning_q, sh_tuning_d;
    logic [1:0]       wave_q, wave_d, sh_wave_q, sh_wave_d;
    logic [CNT_W-1:0] cycles_q, cycles_d, sh_cycles_q, sh_cycles_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stop_q, stop_d, pending_q, pending_d;
    logic             blank_q, blank_d, busy_q, busy_d, done_q, done_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic             acc_en, acc_clr, wrap_next;
    logic             cfg_fire, term_wrap, term_stall;

    carrier_phase_acc #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) u_acc (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (acc_en),
        .clr       (acc_clr),
        .inc       (tuning_q),
        .addr      (address),
        .wrap_next (wrap_next),
        .wrap_n_q  (sync_DA_n)
    );

    assign clk_DA     = clk;
    assign cfg_ready  = cfg_ready_q;
    assign wave_sel   = wave_q;
    assign blank_DA_n = blank_q;
    assign busy       = busy_q;
    assign done       = done_q;

    assign cfg_fire   = cfg_valid && cfg_ready_q;
    // Termination beats a pending config apply on the same wrap.
    assign term_wrap  = wrap_next &&
                        (((cycles_q != '0) && ((count_q + CNT_W'(1)) == cycles_q)) || stop_q);
    // With zero tuning no wrap ever comes, so a stop ends the run directly.
    assign term_stall = (stop || stop_q) && (tuning_q == '0);

    // Next-state, config routing and registered output values.
    always_comb begin
        state_d     = state_q;
        tuning_d    = tuning_q;
        wave_d      = wave_q;
        cycles_d    = cycles_q;
        sh_tuning_d = sh_tuning_q;
        sh_wave_d   = sh_wave_q;
        sh_cycles_d = sh_cycles_q;
        count_d     = count_q;
        stop_d      = stop_q;
        pending_d   = pending_q;
        acc_en      = 1'b0;
        acc_clr     = 1'b1;
        case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    tuning_d = cfg_tuning;
                    wave_d   = cfg_wave;
                    cycles_d = cfg_cycles;
                end
                if (start && !stop) begin
                    state_d = RUN;
                    count_d = '0;
                    stop_d  = 1'b0;
                end
            end
            RUN: begin
                if (stop) stop_d = 1'b1;
                if (term_wrap || term_stall) begin
                    state_d = FINISH;
                end else begin
                    acc_en  = 1'b1;
                    acc_clr = 1'b0;
                    if (wrap_next) begin
                        count_d = count_q + CNT_W'(1);
                        if (pending_q) begin
                            tuning_d  = sh_tuning_q;
                            wave_d    = sh_wave_q;
                            cycles_d  = sh_cycles_q;
                            pending_d = 1'b0;
                        end
                    end
                end
                if (cfg_fire) begin
                    sh_tuning_d = cfg_tuning;
                    sh_wave_d   = cfg_wave;
                    sh_cycles_d = cfg_cycles;
                    pending_d   = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                stop_d  = 1'b0;
                if (pending_q) begin
                    tuning_d  = sh_tuning_q;
                    wave_d    = sh_wave_q;
                    cycles_d  = sh_cycles_q;
                    pending_d = 1'b0;
                end
                // Only reachable with nothing pending (cfg_ready high).
                if (cfg_fire) begin
                    tuning_d = cfg_tuning;
                    wave_d   = cfg_wave;
                    cycles_d = cfg_cycles;
                end
            end
            default: state_d = IDLE;
        endcase
        cfg_ready_d = ~pending_d;
        busy_d      = (state_d != IDLE);
        blank_d     = (state_d == RUN);
        done_d      = (state_d == FINISH);
    end

    // State, config and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tuning_q    <= RESET_TUNING;
            wave_q      <= '0;
            cycles_q    <= '0;
            sh_tuning_q <= RESET_TUNING;
            sh_wave_q   <= '0;
            sh_cycles_q <= '0;
            count_q     <= '0;
            stop_q      <= 1'b0;
            pending_q   <= 1'b0;
            blank_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            tuning_q    <= tuning_d;
            wave_q      <= wave_d;
            cycles_q    <= cycles_d;
            sh_tuning_q <= sh_tuning_d;
            sh_wave_q   <= sh_wave_d;
            sh_cycles_q <= sh_cycles_d;
            count_q     <= count_d;
            stop_q      <= stop_d;
            pending_q   <= pending_d;
            blank_q     <= blank_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

endmodule
